// File: rtl/fmcw_pkg.sv
// -----------------------------------------------------------------------------
// fmcw_pkg
// Shared definitions for the FMCW chirp sequencer:
//   - state_e      : burst sequencer state encoding
//   - NFFT_LSB/W   : position of the log2 FFT size field in the FFT config word
//   - FWD_BIT      : forward/inverse select bit in the FFT config word
//   - DEFAULT_MIN_PERIOD : default lower clamp for the chirp period
//   - fft_cfg_word : builds the FFT config word from a log2 size
// -----------------------------------------------------------------------------
package fmcw_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONFIG = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int NFFT_LSB           = 0;
  localparam int NFFT_W             = 5;
  localparam int FWD_BIT            = 8;
  localparam int CFG_TDATA_W        = 16;
  localparam int DEFAULT_MIN_PERIOD = 8;

  // Forward transform of size 2**nfft; every other bit is left at zero.
  function automatic logic [CFG_TDATA_W-1:0] fft_cfg_word(input logic [NFFT_W-1:0] nfft);
    logic [CFG_TDATA_W-1:0] w;
    w                      = '0;
    w[NFFT_LSB +: NFFT_W]  = nfft;
    w[FWD_BIT]             = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/fmcw_period_timer.sv
// -----------------------------------------------------------------------------
// fmcw_period_timer
// Free-running chirp period counter with ramp pulse generation.
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   enable        : counter runs while high, is held at 0 while low
//   period        : period in aclk cycles (caller guarantees > RAMP_PULSE)
//   ramp          : high while the counter is below RAMP_PULSE
//   rise          : high on the first cycle of each ramp pulse
// -----------------------------------------------------------------------------
module fmcw_period_timer #(
  parameter int PERIOD_WIDTH = 32,
  parameter int RAMP_PULSE   = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    ramp,
  output logic                    rise
);

  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;

  // Holding the counter at zero while disabled makes the first enabled
  // cycle the start of a ramp pulse. The >= compare keeps the counter
  // bounded even if it were ever above period-1.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q >= period - PERIOD_WIDTH'(1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ramp = enable && (cnt_q < PERIOD_WIDTH'(RAMP_PULSE));
  assign rise = enable && (cnt_q == '0);

endmodule

// File: rtl/axis_fmcw_chirp_sequencer.sv
// -----------------------------------------------------------------------------
// axis_fmcw_chirp_sequencer
// Sequences one FMCW measurement burst: programs the FFT core over its AXIS
// config channel, issues cfg_nchirps ramp pulses at a fixed period, then waits
// for the matching number of FFT frames before reporting done.
// Ports:
//   aclk, aresetn          : clock, synchronous active-low reset
//   start, abort           : burst request (IDLE only) / burst stop
//   cfg_period/nchirps/window : burst configuration, latched on start
//   win_cfg_data           : latched cfg_window for the window block
//   ramp                   : chirp trigger pulse (RAMP_PULSE cycles high)
//   m_axis_config_*        : FFT config AXIS master
//   frame_last             : one-cycle strobe per completed FFT frame
//   busy, done             : not-IDLE flag / one-cycle completion pulse
//   err_overrun            : sticky, ramp issued with >= 2 frames outstanding
//   sts_chirp              : ramps issued in the current burst
// -----------------------------------------------------------------------------
module axis_fmcw_chirp_sequencer
  import fmcw_pkg::*;
#(
  parameter int CNT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 32,
  parameter int RAMP_PULSE   = 4,
  parameter int MIN_PERIOD   = DEFAULT_MIN_PERIOD  // must exceed RAMP_PULSE
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0]    cfg_nchirps,
  input  logic [7:0]              cfg_window,
  output logic [7:0]              win_cfg_data,
  output logic                    ramp,
  output logic [CFG_TDATA_W-1:0]  m_axis_config_tdata,
  output logic                    m_axis_config_tvalid,
  input  logic                    m_axis_config_tready,
  input  logic                    frame_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_overrun,
  output logic [CNT_WIDTH-1:0]    sts_chirp
);

  state_e                   state_q;
  logic [PERIOD_WIDTH-1:0]  period_q;
  logic [CNT_WIDTH-1:0]     nchirps_q;
  logic [7:0]               win_q;
  logic [CFG_TDATA_W-1:0]   tdata_q;
  logic                     tvalid_q;
  logic                     err_q;
  logic                     abort_pend_q;
  logic [CNT_WIDTH-1:0]     sts_q;
  logic [CNT_WIDTH-1:0]     frames_q;
  logic [CNT_WIDTH-1:0]     outst_q, outst_d;

  logic                     rise_w;
  logic                     start_ok;
  logic                     frame_ok;
  logic                     cfg_hs;
  logic [PERIOD_WIDTH-1:0]  period_clamped;

  fmcw_period_timer #(
    .PERIOD_WIDTH (PERIOD_WIDTH),
    .RAMP_PULSE   (RAMP_PULSE)
  ) u_timer (
    .aclk    (aclk),
    .aresetn (aresetn),
    .enable  (state_q == RUN),
    .period  (period_q),
    .ramp    (ramp),
    .rise    (rise_w)
  );

  // abort wins over start in the same cycle.
  assign start_ok = (state_q == IDLE) && start && !abort;
  assign cfg_hs   = tvalid_q && m_axis_config_tready;

  // Frames only count while chirps can be in flight, and never below zero.
  assign frame_ok = frame_last && ((state_q == RUN) || (state_q == DRAIN))
                    && (outst_q != '0);

  assign period_clamped = (cfg_period < PERIOD_WIDTH'(MIN_PERIOD))
                          ? PERIOD_WIDTH'(MIN_PERIOD) : cfg_period;

  // Outstanding frames: a coincident ramp rise and accepted frame cancel out.
  always_comb begin
    outst_d = outst_q;
    if (start_ok) begin
      outst_d = '0;
    end else if (rise_w && !frame_ok) begin
      if (outst_q != {CNT_WIDTH{1'b1}}) begin
        outst_d = outst_q + CNT_WIDTH'(1);
      end
    end else if (frame_ok && !rise_w) begin
      outst_d = outst_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      period_q     <= '0;
      nchirps_q    <= '0;
      win_q        <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      sts_q        <= '0;
      frames_q     <= '0;
      outst_q      <= '0;
    end else begin
      outst_q <= outst_d;

      // rise_w is only ever asserted in RUN, so this never collides with
      // the clears done on start in IDLE.
      if (rise_w) begin
        sts_q <= sts_q + CNT_WIDTH'(1);
        if (outst_q >= CNT_WIDTH'(2)) begin
          err_q <= 1'b1;
        end
      end

      if (frame_ok) begin
        frames_q <= frames_q + CNT_WIDTH'(1);
      end

      case (state_q)
        IDLE: begin
          if (start_ok) begin
            period_q     <= period_clamped;
            nchirps_q    <= cfg_nchirps;
            win_q        <= cfg_window;
            tdata_q      <= fft_cfg_word(cfg_window[NFFT_LSB +: NFFT_W]);
            tvalid_q     <= 1'b1;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            sts_q        <= '0;
            frames_q     <= '0;
            state_q      <= CONFIG;
          end
        end

        // An AXIS master may not withdraw tvalid, so abort is remembered
        // and acted on once the FFT core has taken the word.
        CONFIG: begin
          if (abort) begin
            abort_pend_q <= 1'b1;
          end
          if (cfg_hs) begin
            tvalid_q     <= 1'b0;
            abort_pend_q <= 1'b0;
            if (abort || abort_pend_q) begin
              state_q <= IDLE;
            end else if (nchirps_q == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= RUN;
            end
          end
        end

        // Leave only once the final ramp pulse is low, so it keeps its
        // full width.
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (!ramp && (sts_q == nchirps_q)) begin
            state_q <= DRAIN;
          end
        end

        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (frames_q == nchirps_q) begin
            state_q <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign win_cfg_data         = win_q;
  assign m_axis_config_tdata  = tdata_q;
  assign m_axis_config_tvalid = tvalid_q;
  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign err_overrun          = err_q;
  assign sts_chirp            = sts_q;

endmodule

// File: tb/tb_axis_fmcw_chirp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_axis_fmcw_chirp_sequencer
// Directed bench: a table of complete bursts plus hand-written sequences for
// config backpressure, overrun, abort, coincident frame/ramp and reset.
// Outputs are sampled on the falling edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_axis_fmcw_chirp_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic        abort;
  logic [31:0] cfg_period;
  logic [15:0] cfg_nchirps;
  logic [7:0]  cfg_window;
  logic [7:0]  win_cfg_data;
  logic        ramp;
  logic [15:0] m_axis_config_tdata;
  logic        m_axis_config_tvalid;
  logic        m_axis_config_tready;
  logic        frame_last;
  logic        busy;
  logic        done;
  logic        err_overrun;
  logic [15:0] sts_chirp;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int RAMP_PULSE = 4;

  axis_fmcw_chirp_sequencer dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .start                (start),
    .abort                (abort),
    .cfg_period           (cfg_period),
    .cfg_nchirps          (cfg_nchirps),
    .cfg_window           (cfg_window),
    .win_cfg_data         (win_cfg_data),
    .ramp                 (ramp),
    .m_axis_config_tdata  (m_axis_config_tdata),
    .m_axis_config_tvalid (m_axis_config_tvalid),
    .m_axis_config_tready (m_axis_config_tready),
    .frame_last           (frame_last),
    .busy                 (busy),
    .done                 (done),
    .err_overrun          (err_overrun),
    .sts_chirp            (sts_chirp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] period;
    logic [15:0] nchirps;
    logic [7:0]  window;
    bit          bulk_frames;  // 0: frame at each pulse end, 1: all frames after last pulse
    logic [15:0] exp_tdata;
    logic [7:0]  exp_win;
    int          exp_gap;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".win"},    {24'd0, win_cfg_data}, 32'd0);
    check({tag, ".ramp"},   {31'd0, ramp}, 32'd0);
    check({tag, ".tdata"},  {16'd0, m_axis_config_tdata}, 32'd0);
    check({tag, ".tvalid"}, {31'd0, m_axis_config_tvalid}, 32'd0);
    check({tag, ".busy"},   {31'd0, busy}, 32'd0);
    check({tag, ".done"},   {31'd0, done}, 32'd0);
    check({tag, ".err"},    {31'd0, err_overrun}, 32'd0);
    check({tag, ".sts"},    {16'd0, sts_chirp}, 32'd0);
  endtask

  task automatic wait_rise(input int bound, output bit ok);
    logic prev;
    prev = ramp;
    ok   = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge aclk);
      if (ramp && !prev) ok = 1'b1;
      prev = ramp;
    end
  endtask

  task automatic wait_ramp_low(input int bound, output bit ok);
    ok = !ramp;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge aclk);
      if (!ramp) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int bound, output bit ok, output logic err_at,
                           output logic [15:0] sts_at);
    ok = 1'b0; err_at = 1'b0; sts_at = '0;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge aclk);
      if (done) begin
        ok     = 1'b1;
        err_at = err_overrun;
        sts_at = sts_chirp;
      end
    end
  endtask

  // Runs a whole burst from IDLE with tready=1 and checks every observable.
  task automatic run_burst(input vec_t v, input string tag);
    int          rises, hi_len, frames_sent, done_cnt, last_rise, first_rise, bound;
    logic        prev;
    logic [15:0] chirp_at_done;
    logic        err_at_done, busy_after;
    bit          finished, seen_done;
    rises = 0; hi_len = 0; frames_sent = 0; done_cnt = 0; last_rise = 0;
    first_rise = -1; chirp_at_done = '0; err_at_done = 1'b0; busy_after = 1'b1;
    finished = 1'b0; seen_done = 1'b0;
    bound = int'(v.nchirps) * v.exp_gap + 40;

    cfg_period  = v.period;
    cfg_nchirps = v.nchirps;
    cfg_window  = v.window;
    m_axis_config_tready = 1'b1;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    check({tag, ".cfg_tvalid"}, {31'd0, m_axis_config_tvalid}, 32'd1);
    check({tag, ".cfg_tdata"},  {16'd0, m_axis_config_tdata}, {16'd0, v.exp_tdata});
    check({tag, ".win"},        {24'd0, win_cfg_data}, {24'd0, v.exp_win});
    check({tag, ".busy"},       {31'd0, busy}, 32'd1);
    check({tag, ".sts_clear"},  {16'd0, sts_chirp}, 32'd0);
    @(negedge aclk);
    check({tag, ".tvalid_drop"}, {31'd0, m_axis_config_tvalid}, 32'd0);

    prev = 1'b0;
    for (int c = 0; c < bound && !finished; c++) begin
      if (c > 0) @(negedge aclk);
      if (ramp && !prev) begin
        rises++;
        if (rises == 1) first_rise = c;
        else check($sformatf("%s.gap%0d", tag, rises), c - last_rise, v.exp_gap);
        last_rise = c;
        hi_len = 0;
      end
      if (ramp) hi_len++;
      if (!ramp && prev)
        check($sformatf("%s.high%0d", tag, rises), hi_len, RAMP_PULSE);
      if (done) done_cnt++;
      if (seen_done) begin
        finished   = 1'b1;
        busy_after = busy;
      end else if (done) begin
        seen_done     = 1'b1;
        chirp_at_done = sts_chirp;
        err_at_done   = err_overrun;
      end
      frame_last = 1'b0;
      if (!v.bulk_frames && !ramp && prev) frame_last = 1'b1;
      if (v.bulk_frames && rises == int'(v.nchirps) && !ramp && frames_sent < int'(v.nchirps))
        frame_last = 1'b1;
      if (frame_last) frames_sent++;
      prev = ramp;
    end
    frame_last = 1'b0;

    check({tag, ".first_rise"}, first_rise, (v.nchirps == 0) ? -1 : 0);
    check({tag, ".rises"},      rises, {16'd0, v.nchirps});
    check({tag, ".finished"},   {31'd0, finished}, 32'd1);
    check({tag, ".done_cnt"},   done_cnt, 1);
    check({tag, ".sts_done"},   {16'd0, chirp_at_done}, {16'd0, v.nchirps});
    check({tag, ".err_done"},   {31'd0, err_at_done}, {31'd0, v.exp_err});
    check({tag, ".busy_after"}, {31'd0, busy_after}, 32'd0);
    $display("burst %s: period=%0d nchirps=%0d window=0x%02h rises=%0d err=%0b",
             tag, v.period, v.nchirps, v.window, rises, err_at_done);
  endtask

  vec_t vecs[5];

  initial begin
    bit          ok;
    logic        e;
    logic [15:0] s;
    int          bad_v, bad_d, bad_r, dcnt;
    vec_t        v2;

    vecs[0] = '{32'd100, 16'd3, 8'h2A, 1'b0, 16'h010A, 8'h2A, 100, 1'b0};
    vecs[1] = '{32'd3,   16'd2, 8'h1F, 1'b0, 16'h011F, 8'h1F, 8,   1'b0};
    vecs[2] = '{32'd20,  16'd0, 8'hE5, 1'b0, 16'h0105, 8'hE5, 20,  1'b0};
    vecs[3] = '{32'd8,   16'd4, 8'h13, 1'b1, 16'h0113, 8'h13, 8,   1'b1};
    vecs[4] = '{32'd9,   16'd2, 8'h60, 1'b1, 16'h0100, 8'h60, 9,   1'b0};

    aresetn = 1'b0; start = 1'b0; abort = 1'b0; frame_last = 1'b0;
    cfg_period = '0; cfg_nchirps = '0; cfg_window = '0; m_axis_config_tready = 1'b1;
    repeat (3) @(negedge aclk);
    check_all_zero("reset");
    aresetn = 1'b1;
    @(negedge aclk);

    // Table of full bursts
    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i], $sformatf("vec%0d", i));
      @(negedge aclk);
    end

    // Config backpressure: word held stable, no ramp until the handshake
    m_axis_config_tready = 1'b0;
    cfg_period = 32'd10; cfg_nchirps = 16'd1; cfg_window = 8'h07;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    bad_v = 0; bad_d = 0; bad_r = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge aclk);
      if (m_axis_config_tvalid !== 1'b1) bad_v++;
      if (m_axis_config_tdata !== 16'h0107) bad_d++;
      if (ramp !== 1'b0) bad_r++;
    end
    check("bp.tvalid_unstable", bad_v, 0);
    check("bp.tdata_unstable",  bad_d, 0);
    check("bp.early_ramp",      bad_r, 0);
    m_axis_config_tready = 1'b1;
    @(negedge aclk);
    check("bp.tvalid_drop", {31'd0, m_axis_config_tvalid}, 32'd0);
    check("bp.first_ramp",  {31'd0, ramp}, 32'd1);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    check("bp.abort_idle", {31'd0, busy}, 32'd0);
    $display("seq backpressure: held 20 cycles, ramp after handshake");

    // Abort during CONFIG is deferred until the handshake
    m_axis_config_tready = 1'b0;
    cfg_nchirps = 16'd2;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    check("cfgabort.tvalid_held", {31'd0, m_axis_config_tvalid}, 32'd1);
    check("cfgabort.busy_held",   {31'd0, busy}, 32'd1);
    m_axis_config_tready = 1'b1;
    @(negedge aclk);
    check("cfgabort.tvalid", {31'd0, m_axis_config_tvalid}, 32'd0);
    check("cfgabort.busy",   {31'd0, busy}, 32'd0);
    check("cfgabort.ramp",   {31'd0, ramp}, 32'd0);
    $display("seq config-abort: deferred to handshake");

    // Overrun: no frames until all 5 chirps issued
    cfg_period = 32'd50; cfg_nchirps = 16'd5; cfg_window = 8'h0C;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      wait_rise(60, ok);
      check($sformatf("ovr.rise%0d", k), {31'd0, ok}, 32'd1);
      @(negedge aclk);
      check($sformatf("ovr.err_after_rise%0d", k), {31'd0, err_overrun}, (k >= 3) ? 32'd1 : 32'd0);
    end
    wait_ramp_low(10, ok);
    check("ovr.ramp_low", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      frame_last = 1'b1;
      @(negedge aclk);
    end
    frame_last = 1'b0;
    wait_done(20, ok, e, s);
    check("ovr.done",     {31'd0, ok}, 32'd1);
    check("ovr.err_done", {31'd0, e}, 32'd1);
    check("ovr.sts_done", {16'd0, s}, 32'd5);
    @(negedge aclk);
    check("ovr.busy_after", {31'd0, busy}, 32'd0);
    check("ovr.err_sticky", {31'd0, err_overrun}, 32'd1);
    cfg_nchirps = 16'd0;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    check("ovr.err_cleared", {31'd0, err_overrun}, 32'd0);
    wait_done(10, ok, e, s);
    check("ovr.zero_burst_done", {31'd0, ok}, 32'd1);
    @(negedge aclk);
    $display("seq overrun: err set at third rise, cleared by next start");

    // Abort in RUN on the second ramp rise
    cfg_period = 32'd10; cfg_nchirps = 16'd5; cfg_window = 8'h33;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    wait_rise(20, ok);
    check("abort.rise1", {31'd0, ok}, 32'd1);
    wait_rise(20, ok);
    check("abort.rise2", {31'd0, ok}, 32'd1);
    abort = 1'b1;
    @(negedge aclk);
    abort = 1'b0;
    check("abort.ramp", {31'd0, ramp}, 32'd0);
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.sts",  {16'd0, sts_chirp}, 32'd2);
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) dcnt++;
      @(negedge aclk);
    end
    check("abort.no_done", dcnt, 0);
    check("abort.sts_hold", {16'd0, sts_chirp}, 32'd2);
    $display("seq abort: stopped after 2 ramps");
    v2 = '{32'd10, 16'd1, 8'h05, 1'b0, 16'h0105, 8'h05, 10, 1'b0};
    run_burst(v2, "post_abort");
    @(negedge aclk);

    // abort wins over start in the same cycle
    start = 1'b1; abort = 1'b1;
    @(negedge aclk);
    start = 1'b0; abort = 1'b0;
    check("prio.busy",   {31'd0, busy}, 32'd0);
    check("prio.tvalid", {31'd0, m_axis_config_tvalid}, 32'd0);
    $display("seq priority: abort beats start");

    // frame_last coincident with ramp rises 2 and 3
    cfg_period = 32'd8; cfg_nchirps = 16'd3; cfg_window = 8'h08;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    wait_rise(20, ok);
    check("coin.rise1", {31'd0, ok}, 32'd1);
    for (int k = 2; k <= 3; k++) begin
      wait_rise(20, ok);
      check($sformatf("coin.rise%0d", k), {31'd0, ok}, 32'd1);
      frame_last = 1'b1;
      @(negedge aclk);
      frame_last = 1'b0;
    end
    check("coin.no_overrun", {31'd0, err_overrun}, 32'd0);
    wait_ramp_low(10, ok);
    check("coin.ramp_low", {31'd0, ok}, 32'd1);
    frame_last = 1'b1;
    @(negedge aclk);
    frame_last = 1'b0;
    wait_done(20, ok, e, s);
    check("coin.done",     {31'd0, ok}, 32'd1);
    check("coin.err_done", {31'd0, e}, 32'd0);
    check("coin.sts_done", {16'd0, s}, 32'd3);
    @(negedge aclk);
    $display("seq coincident: frames cancel ramp rises");

    // start ignored while busy, then reset in DRAIN
    cfg_period = 32'd8; cfg_nchirps = 16'd3; cfg_window = 8'h1B;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    wait_rise(20, ok);
    check("rst.rise1", {31'd0, ok}, 32'd1);
    cfg_window = 8'h1F; cfg_nchirps = 16'd7;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    check("busy_start.sts",    {16'd0, sts_chirp}, 32'd1);
    check("busy_start.win",    {24'd0, win_cfg_data}, 32'h1B);
    check("busy_start.tvalid", {31'd0, m_axis_config_tvalid}, 32'd0);
    wait_rise(20, ok);
    wait_rise(20, ok);
    check("rst.rise3", {31'd0, ok}, 32'd1);
    repeat (8) @(negedge aclk);
    check("rst.drain_busy", {31'd0, busy}, 32'd1);
    check("rst.drain_err",  {31'd0, err_overrun}, 32'd1);
    check("rst.drain_sts",  {16'd0, sts_chirp}, 32'd3);
    aresetn = 1'b0;
    @(negedge aclk);
    check_all_zero("rst_mid");
    aresetn = 1'b1;
    @(negedge aclk);
    $display("seq reset: mid-drain reset clears outputs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
